// File: rtl/mem_serial_link.sv
// Serial memory link: TX framing (start, header, payload), RX framing with
// start-of-frame sideband capture, and tracking of unanswered commands.
module mem_serial_link #(
    parameter int unsigned IO_BITS            = 2,
    parameter int unsigned MAX_PAYLOAD_CYCLES = 8,
    parameter int unsigned MAX_OUTSTANDING    = 2,
    localparam int unsigned LEN_BITS = $clog2(MAX_PAYLOAD_CYCLES + 1),
    localparam int unsigned OUT_BITS = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                reset,
    // TX command side
    input  logic                tx_command_valid,
    input  logic [IO_BITS-1:0]  tx_command,
    input  logic [LEN_BITS-1:0] tx_len,
    input  logic                tx_expect_reply,
    input  logic [IO_BITS-1:0]  tx_data,
    output logic                tx_command_started,
    output logic                tx_active,
    output logic                tx_header,
    output logic                tx_data_next,
    output logic                tx_done,
    output logic [LEN_BITS-1:0] tx_counter,
    output logic [IO_BITS-1:0]  tx_pins,
    // RX side
    input  logic [IO_BITS-1:0]  rx_pins,
    input  logic [LEN_BITS-1:0] rx_len,
    output logic                rx_started,
    output logic                rx_active,
    output logic                rx_data_valid,
    output logic                rx_done,
    output logic [IO_BITS-1:0]  rx_sbs,
    output logic [LEN_BITS-1:0] rx_counter,
    // Flow control / status
    output logic [OUT_BITS-1:0] outstanding,
    output logic                rx_error
);

    localparam logic [LEN_BITS-1:0] LEN_MAX = LEN_BITS'(MAX_PAYLOAD_CYCLES);
    localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);
    localparam logic [OUT_BITS-1:0] OUT_MAX = OUT_BITS'(MAX_OUTSTANDING);
    localparam logic [OUT_BITS-1:0] OUT_ONE = OUT_BITS'(1);

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_HEADER  = 2'd1,
        TX_PAYLOAD = 2'd2
    } tx_state_e;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_ACTIVE = 1'b1
    } rx_state_e;

    tx_state_e             tx_state_q, tx_state_d;
    logic [IO_BITS-1:0]    tx_cmd_q, tx_cmd_d;
    logic [LEN_BITS-1:0]   tx_len_q, tx_len_d;
    logic [LEN_BITS-1:0]   tx_cnt_q, tx_cnt_d;

    rx_state_e             rx_state_q, rx_state_d;
    logic [LEN_BITS-1:0]   rx_len_q, rx_len_d;
    logic [LEN_BITS-1:0]   rx_cnt_q, rx_cnt_d;
    logic [IO_BITS-1:0]    rx_sbs_q, rx_sbs_d;

    logic [OUT_BITS-1:0]   outstanding_q, outstanding_d;
    logic                  rx_error_q, rx_error_d;

    logic                  out_inc;
    logic                  out_dec;

    // TX state, latched command/length and payload index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cmd_q   <= '0;
            tx_len_q   <= '0;
            tx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cmd_q   <= tx_cmd_d;
            tx_len_q   <= tx_len_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    // TX next state and frame outputs; all strobes forced low while in reset
    always_comb begin
        tx_state_d         = tx_state_q;
        tx_cmd_d           = tx_cmd_q;
        tx_len_d           = tx_len_q;
        tx_cnt_d           = tx_cnt_q;
        tx_command_started = 1'b0;
        tx_active          = 1'b0;
        tx_header          = 1'b0;
        tx_data_next       = 1'b0;
        tx_done            = 1'b0;
        tx_pins            = '0;

        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d           = '0;
                tx_command_started = reset && tx_command_valid &&
                                     !(tx_expect_reply && (outstanding_q == OUT_MAX));
                tx_pins            = IO_BITS'(tx_command_started);
                if (tx_command_started) begin
                    tx_cmd_d   = tx_command;
                    tx_len_d   = (tx_len > LEN_MAX) ? LEN_MAX : tx_len;
                    tx_state_d = TX_HEADER;
                end
            end
            TX_HEADER: begin
                tx_pins   = tx_cmd_q;
                tx_header = 1'b1;
                tx_active = 1'b1;
                tx_cnt_d  = '0;
                if (tx_len_q == '0) begin
                    tx_done    = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_state_d = TX_PAYLOAD;
                end
            end
            TX_PAYLOAD: begin
                tx_pins      = tx_data;
                tx_data_next = 1'b1;
                tx_active    = 1'b1;
                if (tx_cnt_q == tx_len_q - LEN_ONE) begin
                    tx_done    = 1'b1;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + LEN_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = '0;
            end
        endcase

        if (!reset) begin
            tx_command_started = 1'b0;
            tx_active          = 1'b0;
            tx_header          = 1'b0;
            tx_data_next       = 1'b0;
            tx_done            = 1'b0;
            tx_pins            = '0;
        end
    end

    assign tx_counter = tx_cnt_q;

    // RX state, latched length, data index and captured start sideband
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_len_q   <= '0;
            rx_cnt_q   <= '0;
            rx_sbs_q   <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_len_q   <= rx_len_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sbs_q   <= rx_sbs_d;
        end
    end

    // RX next state; a zero length still carries one data cycle
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_len_d      = rx_len_q;
        rx_cnt_d      = rx_cnt_q;
        rx_sbs_d      = rx_sbs_q;
        rx_started    = 1'b0;
        rx_active     = 1'b0;
        rx_data_valid = 1'b0;
        rx_done       = 1'b0;

        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d   = '0;
                rx_started = reset && (rx_pins != '0);
                if (rx_started) begin
                    rx_sbs_d   = rx_pins;
                    rx_state_d = RX_ACTIVE;
                    if (rx_len == '0) begin
                        rx_len_d = LEN_ONE;
                    end else if (rx_len > LEN_MAX) begin
                        rx_len_d = LEN_MAX;
                    end else begin
                        rx_len_d = rx_len;
                    end
                end
            end
            RX_ACTIVE: begin
                rx_active     = 1'b1;
                rx_data_valid = 1'b1;
                if (rx_cnt_q == rx_len_q - LEN_ONE) begin
                    rx_done    = 1'b1;
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + LEN_ONE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = '0;
            end
        endcase

        if (!reset) begin
            rx_started    = 1'b0;
            rx_active     = 1'b0;
            rx_data_valid = 1'b0;
            rx_done       = 1'b0;
        end
    end

    assign rx_counter = rx_cnt_q;
    assign rx_sbs     = rx_sbs_q;

    // Outstanding-command counter and sticky unexpected-reply flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_q <= '0;
            rx_error_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            rx_error_q    <= rx_error_d;
        end
    end

    // A reply arriving with nothing outstanding is flagged and does not
    // consume a command issued in the same cycle
    always_comb begin
        out_inc       = tx_command_started && tx_expect_reply;
        out_dec       = rx_done;
        outstanding_d = outstanding_q;
        rx_error_d    = rx_error_q;

        if (out_dec && (outstanding_q == '0)) begin
            rx_error_d = 1'b1;
            if (out_inc) begin
                outstanding_d = outstanding_q + OUT_ONE;
            end
        end else if (out_inc && !out_dec) begin
            outstanding_d = outstanding_q + OUT_ONE;
        end else if (out_dec && !out_inc) begin
            outstanding_d = outstanding_q - OUT_ONE;
        end
    end

    assign outstanding = outstanding_q;
    assign rx_error    = rx_error_q;

endmodule

// File: tb/tb_mem_serial_link.sv
// Directed bench for mem_serial_link with default parameters.
module tb_mem_serial_link;

    localparam int unsigned IO_BITS  = 2;
    localparam int unsigned LEN_BITS = 4;
    localparam int unsigned OUT_BITS = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                tx_command_valid;
    logic [IO_BITS-1:0]  tx_command;
    logic [LEN_BITS-1:0] tx_len;
    logic                tx_expect_reply;
    logic [IO_BITS-1:0]  tx_data;
    logic                tx_command_started, tx_active, tx_header, tx_data_next, tx_done;
    logic [LEN_BITS-1:0] tx_counter;
    logic [IO_BITS-1:0]  tx_pins;
    logic [IO_BITS-1:0]  rx_pins;
    logic [LEN_BITS-1:0] rx_len;
    logic                rx_started, rx_active, rx_data_valid, rx_done;
    logic [IO_BITS-1:0]  rx_sbs;
    logic [LEN_BITS-1:0] rx_counter;
    logic [OUT_BITS-1:0] outstanding;
    logic                rx_error;

    int checks = 0;
    int errors = 0;

    mem_serial_link #(
        .IO_BITS(2), .MAX_PAYLOAD_CYCLES(8), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_command_valid(tx_command_valid), .tx_command(tx_command),
        .tx_len(tx_len), .tx_expect_reply(tx_expect_reply), .tx_data(tx_data),
        .tx_command_started(tx_command_started), .tx_active(tx_active),
        .tx_header(tx_header), .tx_data_next(tx_data_next), .tx_done(tx_done),
        .tx_counter(tx_counter), .tx_pins(tx_pins),
        .rx_pins(rx_pins), .rx_len(rx_len),
        .rx_started(rx_started), .rx_active(rx_active),
        .rx_data_valid(rx_data_valid), .rx_done(rx_done),
        .rx_sbs(rx_sbs), .rx_counter(rx_counter),
        .outstanding(outstanding), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_inputs();
        tx_command_valid = 1'b0;
        tx_command       = '0;
        tx_len           = '0;
        tx_expect_reply  = 1'b0;
        tx_data          = '0;
        rx_pins          = '0;
        rx_len           = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        tx_command_valid = 1'b1;
        rx_pins          = 2'd3;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({tx_command_started, tx_pins, tx_active, rx_started} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {tx_command_started, tx_pins, tx_active, rx_started});
        end
        checks++;
        if ({outstanding, rx_error, rx_sbs, tx_counter, rx_counter} !== 13'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected 0",
                     {outstanding, rx_error, rx_sbs, tx_counter, rx_counter});
        end
        // Start in the very cycle reset is released
        @(negedge clk);
        reset      = 1'b1;
        rx_pins    = '0;
        tx_command = 2'd1;
        tx_len     = '0;
        #1;
        checks++;
        if ({tx_command_started, tx_pins} !== 3'b101) begin
            errors++;
            $display("FAIL reset_release_start: got %b expected 101", {tx_command_started, tx_pins});
        end
        @(negedge clk);
        tx_command_valid = 1'b0;
        #1;
        checks++;
        if ({tx_header, tx_done, tx_pins} !== 4'b1101) begin
            errors++;
            $display("FAIL reset_release_header: got %b expected 1101", {tx_header, tx_done, tx_pins});
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        @(negedge clk);
        tx_command = 2'd2; tx_len = 4'd3; tx_expect_reply = 1'b0;
        tx_command_valid = 1'b1; tx_data = '0;
        #1;
        checks++;
        if ({tx_command_started, tx_pins} !== 3'b101) begin
            errors++;
            $display("FAIL basic_start: got %b expected 101", {tx_command_started, tx_pins});
        end
        @(negedge clk);
        tx_command_valid = 1'b0; tx_len = '0;
        #1;
        checks++;
        if ({tx_pins, tx_header, tx_active, tx_done, tx_data_next} !== 6'b10_1100) begin
            errors++;
            $display("FAIL basic_header: got %b expected 101100",
                     {tx_pins, tx_header, tx_active, tx_done, tx_data_next});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_data = IO_BITS'(i + 1);
            #1;
            checks++;
            if ({tx_pins, tx_data_next, tx_counter, tx_done} !==
                {IO_BITS'(i + 1), 1'b1, LEN_BITS'(i), (i == 2)}) begin
                errors++;
                $display("FAIL basic_payload%0d: pins=%0d next=%b cnt=%0d done=%b expected pins=%0d next=1 cnt=%0d done=%b",
                         i, tx_pins, tx_data_next, tx_counter, tx_done, i + 1, i, (i == 2));
            end
        end
        @(negedge clk);
        tx_data = '0;
        #1;
        checks++;
        if ({tx_pins, tx_active, tx_counter} !== 7'b0) begin
            errors++;
            $display("FAIL basic_idle: got %b expected 0", {tx_pins, tx_active, tx_counter});
        end
        // Same cycle: back-to-back start right after tx_done
        tx_command = 2'd1; tx_len = '0; tx_command_valid = 1'b1;
        #1;
        checks++;
        if ({tx_command_started, tx_pins} !== 3'b101) begin
            errors++;
            $display("FAIL basic_next_start: got %b expected 101", {tx_command_started, tx_pins});
        end
        @(negedge clk);
        tx_command_valid = 1'b0;
        #1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_len_zero();
        @(negedge clk);
        tx_command = 2'd3; tx_len = '0; tx_command_valid = 1'b1;
        #1;
        @(negedge clk);
        tx_command_valid = 1'b0;
        #1;
        checks++;
        if ({tx_pins, tx_header, tx_done, tx_data_next} !== 5'b11_110) begin
            errors++;
            $display("FAIL len0_header: got %b expected 11110", {tx_pins, tx_header, tx_done, tx_data_next});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({tx_pins, tx_active, tx_data_next} !== 4'b0) begin
            errors++;
            $display("FAIL len0_after: got %b expected 0000", {tx_pins, tx_active, tx_data_next});
        end
    endtask

    task automatic test_len_clamp();
        int nexts;
        nexts = 0;
        @(negedge clk);
        tx_command = 2'd1; tx_len = 4'd15; tx_command_valid = 1'b1;
        #1;
        @(negedge clk);
        tx_command_valid = 1'b0; tx_len = '0;
        #1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tx_data = IO_BITS'(k);
            #1;
            if (tx_data_next === 1'b1) nexts++;
            checks++;
            if ({tx_counter, tx_done} !== {LEN_BITS'(k), (k == 7)}) begin
                errors++;
                $display("FAIL clamp_payload%0d: cnt=%0d done=%b expected cnt=%0d done=%b",
                         k, tx_counter, tx_done, k, (k == 7));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (nexts !== 8 || tx_active !== 1'b0) begin
            errors++;
            $display("FAIL clamp_length: payload cycles=%0d active=%b expected 8 and 0", nexts, tx_active);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        tx_command = 2'd1; tx_len = '0; tx_expect_reply = 1'b1; tx_command_valid = 1'b1;
        #1;
        checks++;
        if (tx_command_started !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_start: got %b expected 1", tx_command_started);
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if ({tx_command_started, outstanding} !== 3'b1_01) begin
            errors++;
            $display("FAIL bp_second_start: got %b expected 101", {tx_command_started, outstanding});
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if ({tx_command_started, outstanding} !== 3'b0_10) begin
            errors++;
            $display("FAIL bp_blocked: got %b expected 010", {tx_command_started, outstanding});
        end
        @(negedge clk);
        rx_pins = 2'd1; rx_len = 4'd1;
        #1;
        checks++;
        if ({rx_started, tx_command_started} !== 2'b10) begin
            errors++;
            $display("FAIL bp_rx_start: got %b expected 10", {rx_started, tx_command_started});
        end
        @(negedge clk);
        rx_pins = '0;
        #1;
        checks++;
        if ({rx_done, rx_counter, tx_command_started} !== 6'b1_0000_0) begin
            errors++;
            $display("FAIL bp_rx_done: got %b expected 100000", {rx_done, rx_counter, tx_command_started});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({tx_command_started, outstanding} !== 3'b1_01) begin
            errors++;
            $display("FAIL bp_unblocked: got %b expected 101", {tx_command_started, outstanding});
        end
        @(negedge clk);
        tx_command_valid = 1'b0;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (outstanding !== 2'd2) begin
            errors++;
            $display("FAIL bp_refill: got %0d expected 2", outstanding);
        end
    endtask

    task automatic test_rx_frame();
        @(negedge clk);
        rx_pins = 2'd3; rx_len = 4'd8;
        #1;
        checks++;
        if (rx_started !== 1'b1) begin
            errors++;
            $display("FAIL rx_start: got %b expected 1", rx_started);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_pins = IO_BITS'(i);
            rx_len  = '0;
            #1;
            checks++;
            if ({rx_sbs, rx_active, rx_data_valid, rx_counter, rx_done, rx_started} !==
                {2'd3, 1'b1, 1'b1, LEN_BITS'(i), (i == 7), 1'b0}) begin
                errors++;
                $display("FAIL rx_data%0d: sbs=%0d act=%b val=%b cnt=%0d done=%b st=%b expected sbs=3 act=1 val=1 cnt=%0d done=%b st=0",
                         i, rx_sbs, rx_active, rx_data_valid, rx_counter, rx_done, rx_started, i, (i == 7));
            end
        end
        @(negedge clk);
        rx_pins = '0;
        #1;
        checks++;
        if ({rx_active, rx_counter, outstanding, rx_error} !== 8'b0_0000_01_0) begin
            errors++;
            $display("FAIL rx_end: got %b expected 00000010", {rx_active, rx_counter, outstanding, rx_error});
        end
    endtask

    task automatic test_coincide();
        @(negedge clk);
        rx_pins = 2'd2; rx_len = '0;
        #1;
        @(negedge clk);
        rx_pins = '0;
        tx_command = 2'd1; tx_len = '0; tx_expect_reply = 1'b1; tx_command_valid = 1'b1;
        #1;
        checks++;
        if ({rx_done, tx_command_started} !== 2'b11) begin
            errors++;
            $display("FAIL coincide_events: got %b expected 11", {rx_done, tx_command_started});
        end
        @(negedge clk);
        tx_command_valid = 1'b0;
        #1;
        checks++;
        if (outstanding !== 2'd1) begin
            errors++;
            $display("FAIL coincide_count: got %0d expected 1", outstanding);
        end
        @(negedge clk);
        rx_pins = 2'd1; rx_len = 4'd1;
        #1;
        @(negedge clk);
        rx_pins = '0;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if ({outstanding, rx_error} !== 3'b00_0) begin
            errors++;
            $display("FAIL drain: got %b expected 000", {outstanding, rx_error});
        end
    endtask

    task automatic test_rx_error();
        @(negedge clk);
        rx_pins = 2'd1; rx_len = 4'd2;
        #1;
        @(negedge clk);
        rx_pins = '0;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if ({rx_done, rx_counter} !== 5'b1_0001) begin
            errors++;
            $display("FAIL err_done: got %b expected 10001", {rx_done, rx_counter});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rx_error, outstanding} !== 3'b1_00) begin
            errors++;
            $display("FAIL err_flag: got %b expected 100", {rx_error, outstanding});
        end
        @(negedge clk);
        #1;
        checks++;
        if (rx_error !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", rx_error);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        tx_command = 2'd2; tx_len = 4'd5; tx_expect_reply = 1'b1; tx_command_valid = 1'b1;
        #1;
        @(negedge clk);
        tx_command_valid = 1'b0;
        #1;
        @(negedge clk);
        tx_data = 2'd3;
        #1;
        checks++;
        if ({tx_pins, tx_data_next, outstanding} !== 5'b11_1_01) begin
            errors++;
            $display("FAIL abort_pre: got %b expected 11101", {tx_pins, tx_data_next, outstanding});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({tx_pins, tx_data_next, tx_active, tx_counter} !== 8'b0) begin
            errors++;
            $display("FAIL abort_tx: got %b expected 0", {tx_pins, tx_data_next, tx_active, tx_counter});
        end
        checks++;
        if ({outstanding, rx_error} !== 3'b0) begin
            errors++;
            $display("FAIL abort_status: got %b expected 000", {outstanding, rx_error});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if ({tx_active, tx_pins} !== 3'b0) begin
            errors++;
            $display("FAIL abort_after: got %b expected 000", {tx_active, tx_pins});
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_len_zero();
        test_len_clamp();
        test_backpressure();
        test_rx_frame();
        test_coincide();
        test_rx_error();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_serial_link.md
MEM_SERIAL_LINK -- requirements
Module: mem_serial_link

Interface
REQ-001 SHALL have parameter IO_BITS, default 2: pin width per direction, also the command width.
REQ-002 SHALL have parameter MAX_PAYLOAD_CYCLES, default 8: maximum payload cycles per frame (2..64).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2: maximum unanswered reply-expecting commands (1..15).
REQ-004 SHALL use derived widths LEN_BITS = clog2(MAX_PAYLOAD_CYCLES+1) and OUT_BITS = clog2(MAX_OUTSTANDING+1).
REQ-005 SHALL provide clk (input, 1): the single clock, all state on its rising edge.
REQ-006 SHALL provide reset (input, 1): asynchronous, active-low; asserted while 0.
REQ-007 SHALL provide tx_command_valid (input, 1): request to start a TX frame.
REQ-008 SHALL provide tx_command (input, IO_BITS): header value; sampled in the start cycle.
REQ-009 SHALL provide tx_len (input, LEN_BITS): TX payload cycles 0..MAX; sampled in the start cycle.
REQ-010 SHALL provide tx_expect_reply (input, 1): command expects one RX frame; sampled in the start cycle.
REQ-011 SHALL provide tx_data (input, IO_BITS): payload stream.
REQ-012 SHALL provide tx_command_started, tx_active, tx_header, tx_data_next and tx_done (outputs, 1 each).
REQ-013 SHALL provide tx_counter (output, LEN_BITS): payload index.
REQ-014 SHALL provide tx_pins (output, IO_BITS) and rx_pins (input, IO_BITS).
REQ-015 SHALL provide rx_len (input, LEN_BITS): RX payload cycles; sampled in the rx_started cycle.
REQ-016 SHALL provide rx_started, rx_active, rx_data_valid and rx_done (outputs, 1 each).
REQ-017 SHALL provide rx_sbs (output, IO_BITS) and rx_counter (output, LEN_BITS).
REQ-018 SHALL provide outstanding (output, OUT_BITS): count of unanswered commands.
REQ-019 SHALL provide rx_error (output, 1): sticky flag for an unexpected RX frame.

Function
REQ-020 TX FSM SHALL have states IDLE, HEADER and PAYLOAD.
REQ-021 tx_command_started = IDLE && tx_command_valid && reset deasserted && !(tx_expect_reply && outstanding==MAX_OUTSTANDING).
REQ-022 In IDLE, tx_pins SHALL be {0..0, tx_command_started}, which makes the start cycle.
REQ-023 In HEADER (one cycle), tx_pins SHALL be the latched command and tx_header=1.
REQ-024 After HEADER, the FSM SHALL go to PAYLOAD if the latched len>0, else to IDLE.
REQ-025 In PAYLOAD, tx_pins=tx_data, tx_data_next=1 and tx_counter counts 0..len-1; then the FSM returns to IDLE.
REQ-026 tx_done SHALL be 1 in the last frame cycle: the last payload cycle, or HEADER when len=0.
REQ-027 tx_active SHALL be 1 in HEADER and PAYLOAD.
REQ-028 The earliest next start SHALL be the cycle after tx_done; tx_counter SHALL be 0 outside PAYLOAD.
REQ-029 tx_len values above MAX_PAYLOAD_CYCLES SHALL be clamped to MAX.
REQ-030 RX FSM SHALL have states IDLE and ACTIVE.
REQ-031 In RX IDLE, rx_pins!=0 SHALL give rx_started=1 (combinational); rx_sbs<=rx_pins and len is latched.
REQ-032 rx_len=0 SHALL be treated as 1, and values above MAX as MAX.
REQ-033 In ACTIVE, rx_active=rx_data_valid=1 and rx_counter counts 0..len-1.
REQ-034 rx_done SHALL be 1 at rx_counter==len-1; the FSM then returns to IDLE.
REQ-035 A new RX start SHALL be allowed in the cycle after rx_done.
REQ-036 rx_counter SHALL be 0 outside ACTIVE.
REQ-037 outstanding SHALL increment on (tx_command_started && tx_expect_reply) and decrement on rx_done.
REQ-038 When increment and decrement coincide, outstanding SHALL be unchanged.
REQ-039 rx_done with outstanding==0 SHALL set rx_error and leave outstanding at 0 (no wrap).
REQ-040 TX and RX SHALL operate fully concurrently.

Reset
REQ-041 While reset=0, both FSMs SHALL be IDLE, counters 0, outstanding=0, rx_error=0 and rx_sbs=0.
REQ-042 While reset=0, tx_pins SHALL be 0 and all strobes 0, including mid-frame (asynchronous abort).
REQ-043 After reset rises, the first start SHALL be possible in the same cycle.

Verification
REQ-044 Defaults, cmd=2, len=3, tx_data=1,2,3 -> tx_pins 1,2,1,2,3,0; tx_done in cycle 5; next start in cycle 6.
REQ-045 len=0 -> tx_pins 1,cmd; tx_done with tx_header; tx_data_next never 1.
REQ-046 Two reply-expecting starts, then valid held -> blocked; started in the cycle after the first rx_done.
REQ-047 rx_pins=3 then 8 data cycles, rx_len=8 -> rx_sbs=3; rx_counter 0..7; rx_done at 7.
REQ-048 rx_done coinciding with a reply-expecting start -> outstanding unchanged.
REQ-049 RX frame with outstanding=0 -> rx_error=1.
REQ-050 reset=0 in PAYLOAD -> tx_pins=0 immediately, outstanding=0.
